// File: rtl/nios2_mul_arbiter.sv
// nios2_mul_arbiter
// -----------------
// Shares one pipelined multiplier cell (low DATA_W bits of the product)
// between two requesters using round-robin arbitration. Each requester can
// have at most one operation outstanding. A {valid, id} tag pipeline, which
// runs in step with the cell, routes each product into that requester's
// one-entry response buffer.
//
// Handshake semantics (both request and response channels):
//   A transfer happens on a rising clk edge where valid & ready are both high.
//   req*_ready is a combinational grant and may depend on req*_valid.
//   A requester keeps its operands stable while valid is high and ready is low.
//   rsp*_valid / rsp*_result stay stable until rsp*_ready is seen.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req{0,1}_valid/ready       request channel handshake
//   req{0,1}_src1/src2         operands
//   rsp{0,1}_valid/ready       response channel handshake
//   rsp{0,1}_result            buffered product, low DATA_W bits
//   mul_src1/mul_src2          operands to the cell; zero when there is no grant
//   mul_result                 cell output, MUL_LATENCY cycles after its operands
//   perf_grant{0,1}_cnt        grant counters            (NIOS2_MUL_ARB_PERF_CNT_EN)
//   perf_conflict_cnt          both-eligible cycle count (NIOS2_MUL_ARB_PERF_CNT_EN)
//
// Build option:
//   `define NIOS2_MUL_ARB_PERF_CNT_EN builds the performance counters.
//   Without it the perf ports are tied to zero. Arbitration is the same
//   either way.
//
// Parameters:
//   MUL_LATENCY  cell latency in cycles, 1..4
//   DATA_W       operand and result width

module nios2_mul_arbiter #(
  parameter int MUL_LATENCY = 1,
  parameter int DATA_W      = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,

  output logic [DATA_W-1:0] mul_src1,
  output logic [DATA_W-1:0] mul_src2,
  input  logic [DATA_W-1:0] mul_result,

  output logic [31:0]       perf_grant0_cnt,
  output logic [31:0]       perf_grant1_cnt,
  output logic [31:0]       perf_conflict_cnt
);

  // Round-robin pointer: the requester that wins when both are eligible.
  logic rr_ptr;

  // Set at grant, cleared at result capture.
  logic inflight0;
  logic inflight1;

  // Tag pipeline; stage s holds the op issued s+1 cycles ago.
  logic [MUL_LATENCY-1:0] tag_vld;
  logic [MUL_LATENCY-1:0] tag_id;

  logic busy0, busy1;
  logic elig0, elig1;
  logic grant0, grant1;
  logic cap0, cap1;

  // busy is built only from registered state, so a requester can be
  // regranted no earlier than the cycle after its response handshake.
  assign busy0 = inflight0 | rsp0_valid;
  assign busy1 = inflight1 | rsp1_valid;
  assign elig0 = req0_valid & ~busy0;
  assign elig1 = req1_valid & ~busy1;

  // Grants are suppressed during reset so ready reads 0 while reset is high.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (elig0 && elig1) begin
        grant0 = ~rr_ptr;
        grant1 = rr_ptr;
      end else begin
        grant0 = elig0;
        grant1 = elig1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    mul_src1 = '0;
    mul_src2 = '0;
    if (grant0) begin
      mul_src1 = req0_src1;
      mul_src2 = req0_src2;
    end else if (grant1) begin
      mul_src1 = req1_src1;
      mul_src2 = req1_src2;
    end
  end

  // The last tag stage lines up with the cycle in which mul_result holds
  // the product of that op.
  assign cap0 = tag_vld[MUL_LATENCY-1] & ~tag_id[MUL_LATENCY-1];
  assign cap1 = tag_vld[MUL_LATENCY-1] &  tag_id[MUL_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr      <= 1'b0;
      inflight0   <= 1'b0;
      inflight1   <= 1'b0;
      tag_vld     <= '0;
      tag_id      <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
    end else begin
      // The winner moves to the back of the line.
      if (grant0 || grant1) begin
        rr_ptr <= grant0;
      end

      tag_vld[0] <= grant0 | grant1;
      tag_id[0]  <= grant1;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end

      // A grant needs ~inflight, so set and clear never collide.
      if (cap0)   inflight0 <= 1'b0;
      if (grant0) inflight0 <= 1'b1;
      if (cap1)   inflight1 <= 1'b0;
      if (grant1) inflight1 <= 1'b1;

      // A capture cannot meet a pending response for the same requester
      // because only one op per requester can be outstanding.
      if (cap0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= mul_result;
      end else if (rsp0_valid && rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end

      if (cap1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= mul_result;
      end else if (rsp1_valid && rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end
    end
  end

`ifdef NIOS2_MUL_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_grant0_cnt   <= '0;
      perf_grant1_cnt   <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (grant0)         perf_grant0_cnt   <= perf_grant0_cnt + 32'd1;
      if (grant1)         perf_grant1_cnt   <= perf_grant1_cnt + 32'd1;
      if (elig0 && elig1) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`else
  assign perf_grant0_cnt   = '0;
  assign perf_grant1_cnt   = '0;
  assign perf_conflict_cnt = '0;
`endif

endmodule
